// File: rtl/seg_disp_arbiter.sv
// seg_disp_arbiter: round-robin owner selection for one shared 8-digit
// seven-segment driver. Each grant holds the display for at least DWELL
// cycles so the value stays readable. While it holds the display, the
// owner's changed data is pushed through without restarting the dwell.

// Per-requester qualification: one instance per requester.
module seg_disp_arb_lane (
  input  logic        req_i,
  input  logic        is_owner_i,
  input  logic [31:0] data_i,
  input  logic [31:0] disp_data_i,
  output logic        other_req_o,
  output logic        live_upd_o
);
  // A non-owner request competes at expiry. An owner request with new data
  // asks for a live re-capture.
  always_comb begin
    other_req_o = req_i & ~is_owner_i;
    live_upd_o  = req_i & is_owner_i & (data_i != disp_data_i);
  end
endmodule

module seg_disp_arbiter #(
  parameter int NREQ  = 4,
  parameter int DWELL = 100000000,
  parameter int CW    = 27
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [32*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      ack,
  output logic                 disp_cs,
  output logic [31:0]          disp_data,
  output logic [1:0]           owner,
  output logic                 busy
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q,   cnt_d;
  logic [1:0]            last_q,  last_d;
  logic [1:0]            owner_q, owner_d;
  logic [31:0]           data_q,  data_d;
  logic [NREQ-1:0]       ack_q,   ack_d;
  logic                  cs_q,    cs_d;
  logic                  busy_q,  busy_d;

  logic [NREQ-1:0][31:0] lane_data;
  logic [NREQ-1:0]       own_oh;
  logic [NREQ-1:0]       other_req;
  logic [NREQ-1:0]       live_upd;

  logic [2:0]            pick_all, pick_oth;
  logic                  expire;
  logic                  grant_en;
  logic [1:0]            grant_idx;

  // Scan starts one past the last winner and wraps. Index 'last' itself
  // comes last in the scan. Result is {found, index}.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] lst);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 1; i <= 4; i++) begin
      idx = lst + 2'(i);
      if (!res[2] && r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign own_oh = NREQ'(1) << owner_q;

  genvar g;
  generate
    for (g = 0; g < NREQ; g++) begin : g_lane
      assign lane_data[g] = req_data[32*g +: 32];
      seg_disp_arb_lane u_lane (
        .req_i       (req[g]),
        .is_owner_i  (own_oh[g]),
        .data_i      (lane_data[g]),
        .disp_data_i (data_q),
        .other_req_o (other_req[g]),
        .live_upd_o  (live_upd[g])
      );
    end
  endgenerate

  assign pick_all = rr_pick(req, last_q);
  assign pick_oth = rr_pick(other_req, last_q);
  assign expire   = (cnt_q == CW'(DWELL - 1));

  // Next-state logic. At expiry, the decision takes priority over a live update.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    owner_d   = owner_q;
    data_d    = data_q;
    busy_d    = busy_q;
    ack_d     = '0;
    cs_d      = 1'b0;
    grant_en  = 1'b0;
    grant_idx = 2'd0;
    case (state_q)
      S_IDLE: begin
        if (pick_all[2]) begin
          grant_en  = 1'b1;
          grant_idx = pick_all[1:0];
        end
      end
      S_HOLD: begin
        cnt_d = cnt_q + CW'(1);
        if (expire) begin
          if (pick_oth[2]) begin
            grant_en  = 1'b1;
            grant_idx = pick_oth[1:0];
          end else if (req[owner_q]) begin
            cnt_d = '0;
          end else begin
            cnt_d   = '0;
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end else if (|live_upd) begin
          data_d = lane_data[owner_q];
          cs_d   = 1'b1;
          ack_d  = own_oh;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (grant_en) begin
      data_d  = lane_data[grant_idx];
      cs_d    = 1'b1;
      ack_d   = NREQ'(1) << grant_idx;
      owner_d = grant_idx;
      last_d  = grant_idx;
      cnt_d   = '0;
      state_d = S_HOLD;
      busy_d  = 1'b1;
    end
  end

  // State registers. The RR pointer resets to 3, so requester 0 wins first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      last_q  <= 2'd3;
      owner_q <= 2'd0;
      data_q  <= '0;
      ack_q   <= '0;
      cs_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      cs_q    <= cs_d;
      busy_q  <= busy_d;
    end
  end

  assign ack       = ack_q;
  assign disp_cs   = cs_q;
  assign disp_data = data_q;
  assign owner     = owner_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// Directed bench for seg_disp_arbiter with DWELL=8.
module tb_seg_disp_arbiter;
  localparam int DW = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   req = '0;
  logic [127:0] req_data = '0;
  logic [3:0]   ack;
  logic         disp_cs;
  logic [31:0]  disp_data;
  logic [1:0]   owner;
  logic         busy;

  int tests = 0;
  int failed = 0;

  seg_disp_arbiter #(.NREQ(4), .DWELL(DW), .CW(4)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .ack(ack), .disp_cs(disp_cs), .disp_data(disp_data),
    .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input int idx, input logic [31:0] v);
    req_data[32*idx +: 32] = v;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Check one full grant: cs, ack, owner, data, busy.
  task automatic chk_grant(input string tag, input logic [1:0] who, input logic [31:0] d);
    chk({tag, ".cs"}, 32'(disp_cs), 32'd1);
    chk({tag, ".ack"}, 32'(ack), 32'(4'b0001 << who));
    chk({tag, ".owner"}, 32'(owner), 32'(who));
    chk({tag, ".data"}, disp_data, d);
    chk({tag, ".busy"}, 32'(busy), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: single request, then drop; busy clears after 8 HOLD cycles
    do_reset();
    chk("rst.ack", 32'(ack), 32'd0);
    chk("rst.cs", 32'(disp_cs), 32'd0);
    chk("rst.data", disp_data, 32'd0);
    chk("rst.owner", 32'(owner), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    set_data(2, 32'h12345678);
    req = 4'b0100;
    tick();
    chk_grant("t1.grant", 2'd2, 32'h12345678);
    req = 4'b0000;
    tick();
    chk("t1.cs_pulse", 32'(disp_cs), 32'd0);
    chk("t1.ack_pulse", 32'(ack), 32'd0);
    repeat (6) tick();
    chk("t1.busy7", 32'(busy), 32'd1);
    tick();
    chk("t1.busy8", 32'(busy), 32'd0);
    chk("t1.data_kept", disp_data, 32'h12345678);
    tick();
    chk("t1.idle_cs", 32'(disp_cs), 32'd0);

    // 2: all requesting, round-robin 0,1,2,3,0 exactly 8 cycles apart
    do_reset();
    for (int i = 0; i < 4; i++) set_data(i, 32'h11111111 * (i + 1));
    req = 4'b1111;
    tick();
    chk_grant("t2.g0", 2'd0, 32'h11111111);
    for (int g = 1; g <= 4; g++) begin
      for (int c = 0; c < DW - 1; c++) begin
        tick();
        chk("t2.no_cs", 32'(disp_cs), 32'd0);
      end
      tick();
      chk_grant("t2.gn", 2'(g % 4), 32'h11111111 * ((g % 4) + 1));
    end

    // 3: live update at HOLD cycle 3, expiry still at cycle 8
    do_reset();
    set_data(1, 32'hA);
    req = 4'b0010;
    tick();
    chk_grant("t3.grant", 2'd1, 32'hA);
    repeat (3) tick();
    set_data(1, 32'hB);
    tick();
    chk("t3.upd_cs", 32'(disp_cs), 32'd1);
    chk("t3.upd_ack", 32'(ack), 32'b0010);
    chk("t3.upd_data", disp_data, 32'hB);
    tick();
    chk("t3.upd_once", 32'(disp_cs), 32'd0);
    req = 4'b0000;
    repeat (2) tick();
    chk("t3.busy7", 32'(busy), 32'd1);
    tick();
    chk("t3.busy8", 32'(busy), 32'd0);

    // 4: lone owner re-holds silently; req[0] takes over at next boundary
    do_reset();
    set_data(3, 32'hC0FFEE03);
    set_data(0, 32'hC0FFEE00);
    req = 4'b1000;
    tick();
    chk_grant("t4.grant", 2'd3, 32'hC0FFEE03);
    for (int c = 0; c < 2 * DW; c++) begin
      tick();
      chk("t4.quiet_cs", 32'(disp_cs), 32'd0);
    end
    chk("t4.still_busy", 32'(busy), 32'd1);
    chk("t4.still_owner", 32'(owner), 32'd3);
    req = 4'b1001;
    repeat (DW - 1) tick();
    chk("t4.pre_owner", 32'(owner), 32'd3);
    chk("t4.pre_cs", 32'(disp_cs), 32'd0);
    tick();
    chk_grant("t4.switch", 2'd0, 32'hC0FFEE00);

    // 5: owner drops at cycle 2, req[0] at cycle 5, switch only at expiry
    do_reset();
    set_data(2, 32'h22222222);
    set_data(0, 32'h00000AAA);
    req = 4'b0100;
    tick();
    chk_grant("t5.grant", 2'd2, 32'h22222222);
    repeat (2) tick();
    req = 4'b0000;
    repeat (3) tick();
    req = 4'b0001;
    tick();
    chk("t5.c6_owner", 32'(owner), 32'd2);
    chk("t5.c6_cs", 32'(disp_cs), 32'd0);
    tick();
    chk("t5.c7_busy", 32'(busy), 32'd1);
    tick();
    chk_grant("t5.expire", 2'd0, 32'h00000AAA);

    // 6: reset asserted mid-HOLD clears outputs at once; RR pointer restarts
    do_reset();
    set_data(2, 32'h55AA55AA);
    req = 4'b0100;
    tick();
    chk_grant("t6.grant", 2'd2, 32'h55AA55AA);
    repeat (4) tick();
    reset = 1'b1;
    #1;
    chk("t6.rst_data", disp_data, 32'd0);
    chk("t6.rst_owner", 32'(owner), 32'd0);
    chk("t6.rst_busy", 32'(busy), 32'd0);
    chk("t6.rst_ack", 32'(ack), 32'd0);
    tick();
    set_data(3, 32'h33333333);
    set_data(0, 32'h0000F00D);
    req = 4'b1000;
    reset = 1'b0;
    tick();
    chk_grant("t6.regrant", 2'd3, 32'h33333333);
    req = 4'b1111;
    repeat (DW - 1) tick();
    chk("t6.pre_owner", 32'(owner), 32'd3);
    tick();
    chk_grant("t6.next", 2'd0, 32'h0000F00D);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
